// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter: serialises I-cache fills, D-cache fills and
// write-through stores onto one memory4c port and bursts WORDS-word block fills.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WORDS  = 8,
  localparam int unsigned CNT_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache fill requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_valid,
  output logic [CNT_W-1:0]  i_word_idx,
  output logic              i_done,
  output logic [DATA_W-1:0] i_data,
  // D-cache fill requester
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_grant,
  output logic              d_data_valid,
  output logic [CNT_W-1:0]  d_word_idx,
  output logic              d_done,
  output logic [DATA_W-1:0] d_data,
  // Write-through store requester
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ack,
  // memory4c port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_enable,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid
);

  localparam int unsigned BSH   = $clog2(DATA_W / 8);
  localparam int unsigned OFF_W = CNT_W + BSH;
  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [CNT_W-1:0]  LastCnt = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFillI, StFillD, StWrite} state_t;

  state_t              r_state;
  logic                r_last_d;      // last fill served was D-side
  logic                r_wr_streak;   // last grant was a write
  logic [CNT_W-1:0]    r_issue_cnt;
  logic [CNT_W-1:0]    r_rcv_cnt;
  logic [ADDR_W-1:0]   r_base;
  logic                r_i_grant;
  logic                r_d_grant;
  logic                r_mem_enable;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_data_in;
  logic                r_w_ack;

  logic                w_fill_pend;
  logic                w_pick_w;
  logic                w_pick_i;
  logic                w_rcv;
  logic                w_last_rcv;
  logic [ADDR_W-1:0]   w_fill_addr;
  logic [ADDR_W-1:0]   w_base;
  logic [CNT_W-1:0]    w_issue_nxt;
  logic [ADDR_W-1:0]   w_next_addr;

  // A write may not win twice in a row while a fill is waiting.
  assign w_fill_pend = i_req | d_req;
  assign w_pick_w    = w_req & ~(r_wr_streak & w_fill_pend);
  assign w_pick_i    = i_req & (~d_req | r_last_d);
  assign w_fill_addr = w_pick_i ? i_addr : d_addr;
  assign w_base      = w_fill_addr & ~OffMask;
  assign w_issue_nxt = r_issue_cnt + CNT_W'(1);
  assign w_next_addr = r_base + (ADDR_W'(w_issue_nxt) << BSH);

  // Returned words are only accepted while a fill owns the port.
  assign w_rcv       = mem_data_valid & ((r_state == StFillI) | (r_state == StFillD));
  assign w_last_rcv  = w_rcv & (r_rcv_cnt == LastCnt);

  assign i_data       = mem_data_out;
  assign d_data       = mem_data_out;
  assign i_data_valid = (r_state == StFillI) & mem_data_valid;
  assign d_data_valid = (r_state == StFillD) & mem_data_valid;
  assign i_word_idx   = (r_state == StFillI) ? r_rcv_cnt : '0;
  assign d_word_idx   = (r_state == StFillD) ? r_rcv_cnt : '0;
  assign i_done       = i_data_valid & (r_rcv_cnt == LastCnt);
  assign d_done       = d_data_valid & (r_rcv_cnt == LastCnt);

  assign i_grant     = r_i_grant;
  assign d_grant     = r_d_grant;
  assign w_ack       = r_w_ack;
  assign mem_addr    = r_mem_addr;
  assign mem_data_in = r_mem_data_in;
  assign mem_enable  = r_mem_enable;
  assign mem_wr      = r_mem_wr;

  // Arbitration FSM with registered grants and memory-port drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_last_d      <= 1'b1;
      r_wr_streak   <= 1'b0;
      r_issue_cnt   <= '0;
      r_rcv_cnt     <= '0;
      r_base        <= '0;
      r_i_grant     <= 1'b0;
      r_d_grant     <= 1'b0;
      r_mem_enable  <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
      r_w_ack       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pick_w) begin
            r_state       <= StWrite;
            r_wr_streak   <= 1'b1;
            r_mem_enable  <= 1'b1;
            r_mem_wr      <= 1'b1;
            r_mem_addr    <= w_addr;
            r_mem_data_in <= w_data;
            r_w_ack       <= 1'b1;
          end else if (w_fill_pend) begin
            r_state      <= w_pick_i ? StFillI : StFillD;
            r_i_grant    <= w_pick_i;
            r_d_grant    <= ~w_pick_i;
            r_last_d     <= ~w_pick_i;
            r_wr_streak  <= 1'b0;
            r_base       <= w_base;
            r_mem_enable <= 1'b1;
            r_mem_addr   <= w_base;
            r_issue_cnt  <= '0;
            r_rcv_cnt    <= '0;
          end
        end
        StFillI, StFillD: begin
          if (r_mem_enable) begin
            if (r_issue_cnt == LastCnt) begin
              r_mem_enable <= 1'b0;
              r_mem_addr   <= '0;
              r_issue_cnt  <= '0;
            end else begin
              r_issue_cnt <= w_issue_nxt;
              r_mem_addr  <= w_next_addr;
            end
          end
          if (w_rcv) begin
            r_rcv_cnt <= r_rcv_cnt + CNT_W'(1);
          end
          if (w_last_rcv) begin
            r_state      <= StIdle;
            r_i_grant    <= 1'b0;
            r_d_grant    <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_addr   <= '0;
            r_issue_cnt  <= '0;
            r_rcv_cnt    <= '0;
          end
        end
        StWrite: begin
          r_state       <= StIdle;
          r_mem_enable  <= 1'b0;
          r_mem_wr      <= 1'b0;
          r_mem_addr    <= '0;
          r_mem_data_in <= '0;
          r_w_ack       <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model with random latency, per-cycle fill/write
// checks and a transaction-level arbitration model predicting grant order.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, w_req;
  logic [15:0] i_addr, d_addr, w_addr, w_data;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic        i_grant, i_data_valid, i_done, d_grant, d_data_valid, d_done, w_ack;
  logic [2:0]  i_word_idx, d_word_idx;
  logic [15:0] i_data, d_data, mem_addr, mem_data_in;
  logic        mem_enable, mem_wr;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_valid(i_data_valid),
    .i_word_idx(i_word_idx), .i_done(i_done), .i_data(i_data),
    .d_req(d_req), .d_addr(d_addr), .d_grant(d_grant), .d_data_valid(d_data_valid),
    .d_word_idx(d_word_idx), .d_done(d_done), .d_data(d_data),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ack(w_ack),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {int t; logic [15:0] a;} rd_t;

  int          n_err = 0;
  int          n_chk = 0;
  logic [15:0] mem [0:32767];
  rd_t         rdq[$];
  int          last_t = 0;
  int          cyc = 0;
  int          n_mdv = 0;
  bit          man_pulse = 0;
  bit          pg[2];
  int          k[2];
  int          r[2];
  logic [15:0] base[2];
  logic [15:0] pa[2];
  logic [15:0] pw_addr, pw_data;
  bit          prst;
  int          done_cyc[2];
  int          ack_cyc;
  bit          hold[2];
  bit          w_hold;
  byte         rec[$];
  // Arbitration model flags
  bit          m_last_d = 1;
  bit          m_streak = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Winner among the pending set according to the fairness rules.
  function automatic byte pick(input bit pi, input bit pd, input bit pw);
    if (pw && !(m_streak && (pi || pd))) begin
      m_streak = 1;
      return "W";
    end
    m_streak = 0;
    if (pi && (!pd || m_last_d)) begin
      m_last_d = 0;
      return "I";
    end
    m_last_d = 1;
    return "D";
  endfunction

  task automatic monitor();
    bit g[2], dv[2], dn[2], rose[2];
    logic [2:0]  idx[2];
    logic [15:0] dat[2];
    g[0] = i_grant; g[1] = d_grant; dv[0] = i_data_valid; dv[1] = d_data_valid;
    dn[0] = i_done; dn[1] = d_done; idx[0] = i_word_idx; idx[1] = d_word_idx;
    dat[0] = i_data; dat[1] = d_data;
    if (prst) begin
      pg[0] = 0; pg[1] = 0; m_last_d = 1; m_streak = 0;
    end
    for (int x = 0; x < 2; x++) begin
      rose[x] = g[x] && !pg[x];
      if (rose[x]) begin
        rec.push_back(x == 0 ? "I" : "D");
        k[x] = 0; r[x] = 0; base[x] = pa[x] & 16'hFFF0;
      end
      if (!g[x] && pg[x]) chk("fill_len", r[x], 8);
      if (g[x]) begin
        if (mem_enable) begin
          chk("fill_rd", mem_wr, 0);
          chk("fill_addr", mem_addr, base[x] + 16'(2 * k[x]));
          k[x]++;
        end else begin
          chk("issue_cnt", k[x], 8);
        end
      end
      if (g[x] && mem_data_valid) begin
        chk("data_valid", dv[x], 1);
        chk("word_idx", idx[x], r[x] % 8);
        chk("fill_data", dat[x], mem[int'(base[x] >> 1) + r[x]]);
        chk("done", dn[x], r[x] == 7);
        if (dn[x]) done_cyc[x] = cyc;
        r[x]++;
      end else begin
        chk("no_data_valid", dv[x], 0);
        chk("no_done", dn[x], 0);
      end
      pg[x] = g[x];
    end
    if (w_ack) begin
      rec.push_back("W");
      chk("wr_en", mem_enable && mem_wr, 1);
      chk("wr_addr", mem_addr, pw_addr);
      chk("wr_data", mem_data_in, pw_data);
      ack_cyc = cyc;
    end
    chk("one_owner", (32'(g[0]) + 32'(g[1]) + 32'(w_ack)) <= 1, 1);
    if (!g[0] && !g[1] && !w_ack) chk("idle_en", mem_enable, 0);
    // Requesters: drop at completion unless holding; new address after grant is ignored.
    if (i_done && !hold[0]) i_req = 0;
    if (d_done && !hold[1]) d_req = 0;
    if (w_ack && !w_hold) w_req = 0;
    if (rose[0]) i_addr = 16'($urandom);
    if (rose[1]) d_addr = 16'($urandom);
  endtask

  task automatic tick();
    int t;
    pa[0] = i_addr; pa[1] = d_addr; pw_addr = w_addr; pw_data = w_data; prst = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_enable === 1'b1 && mem_wr === 1'b1) mem[mem_addr[15:1]] = mem_data_in;
    if (mem_enable === 1'b1 && mem_wr === 1'b0) begin
      t = cyc + int'($urandom_range(1, 4));
      if (t <= last_t) t = last_t + 1;
      last_t = t;
      rdq.push_back('{t, mem_addr});
    end
    mem_data_valid = 0;
    mem_data_out = 16'($urandom);
    if (rdq.size() > 0 && rdq[0].t <= cyc) begin
      mem_data_valid = 1;
      mem_data_out = mem[rdq[0].a[15:1]];
      void'(rdq.pop_front());
    end else if (man_pulse) begin
      mem_data_valid = 1;
      man_pulse = 0;
    end
    if (mem_data_valid) n_mdv++;
    #1;
    monitor();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ig"}, i_grant, 0);   chk({tag, "_dg"}, d_grant, 0);
    chk({tag, "_idv"}, i_data_valid, 0); chk({tag, "_ddv"}, d_data_valid, 0);
    chk({tag, "_iidx"}, i_word_idx, 0);  chk({tag, "_didx"}, d_word_idx, 0);
    chk({tag, "_idn"}, i_done, 0);   chk({tag, "_ddn"}, d_done, 0);
    chk({tag, "_ack"}, w_ack, 0);    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_din"}, mem_data_in, 0);
    chk({tag, "_en"}, mem_enable, 0); chk({tag, "_wr"}, mem_wr, 0);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((i_req || d_req || w_req || i_grant || d_grant || mem_enable) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < budget, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (rdq.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_timeout", rdq.size(), 0);
  endtask

  task automatic compare_order(input byte e[$]);
    chk("order_len", rec.size(), e.size());
    for (int i = 0; i < e.size() && i < rec.size(); i++) chk("order", rec[i], e[i]);
  endtask

  task automatic serve_set(input bit si, input bit sd, input bit sw);
    bit  pi = si, pd = sd, pw = sw;
    byte e[$];
    byte c;
    rec.delete();
    while (pi || pd || pw) begin
      c = pick(pi, pd, pw);
      e.push_back(c);
      if (c == "I") pi = 0;
      else if (c == "D") pd = 0;
      else pw = 0;
    end
    i_addr = 16'($urandom); d_addr = 16'($urandom);
    w_addr = 16'($urandom); w_data = 16'($urandom);
    i_req = si; d_req = sd; w_req = sw;
    run_until_idle(400);
    compare_order(e);
  endtask

  task automatic do_reset();
    rst = 1; i_req = 0; d_req = 0; w_req = 0;
    hold[0] = 0; hold[1] = 0; w_hold = 0;
    tick();
    check_all_zero("rst");
    tick();
    rst = 0;
    drain();
  endtask

  initial begin
    byte e[$];
    int  n, mdv0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    rst = 1; i_req = 0; d_req = 0; w_req = 0;
    i_addr = 0; d_addr = 0; w_addr = 0; w_data = 0;
    mem_data_valid = 0; mem_data_out = 0;
    do_reset();

    // Single I fill from 0x1236: grant and first address the next cycle.
    rec.delete();
    e.delete();
    e.push_back(pick(1, 0, 0));
    i_addr = 16'h1236;
    i_req = 1;
    tick();
    chk("t1_grant", i_grant, 1);
    chk("t1_en", mem_enable, 1);
    chk("t1_addr0", mem_addr, 16'h1230);
    run_until_idle(100);
    compare_order(e);

    // Simultaneous I/D after reset, then round-robin after a lone I.
    serve_set(1, 1, 0);
    serve_set(1, 0, 0);
    serve_set(1, 1, 0);

    // Write raised mid D fill waits for d_done, issues two cycles later.
    rec.delete();
    e.delete();
    e.push_back(pick(0, 1, 0));
    e.push_back(pick(0, 0, 1));
    d_addr = 16'($urandom);
    d_req = 1;
    n = 0;
    while (!(d_grant && k[1] == 3) && n < 50) begin
      tick();
      n++;
    end
    chk("t3_reach", n < 50, 1);
    w_addr = 16'h0400; w_data = 16'hBEEF; w_req = 1;
    run_until_idle(200);
    chk("t3_ack_timing", ack_cyc, done_cyc[1] + 2);
    chk("t3_mem", mem[16'h0400 >> 1], 16'hBEEF);
    compare_order(e);

    // Continuous write pressure with I pending must alternate.
    rec.delete();
    e.delete();
    for (int i = 0; i < 6; i++) e.push_back(pick(1, 0, 1));
    hold[0] = 1; w_hold = 1; i_req = 1; w_req = 1;
    i_addr = 16'($urandom); w_addr = 16'($urandom); w_data = 16'($urandom);
    n = 0;
    while (rec.size() < 6 && n < 400) begin
      tick();
      n++;
    end
    chk("t4_reach", n < 400, 1);
    compare_order(e);
    do_reset();

    // Reset on the 3rd issued word of an I fill; late data is ignored.
    i_addr = 16'($urandom);
    i_req = 1;
    n = 0;
    while (!(i_grant && k[0] == 3) && n < 50) begin
      tick();
      n++;
    end
    chk("t5_reach", n < 50, 1);
    mdv0 = n_mdv;
    rst = 1; i_req = 0;
    tick();
    check_all_zero("t5");
    rst = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("t5_late_seen", (n_mdv - mdv0) > 0, 1);
    drain();

    // Stray data_valid while idle, then fills must still index from 0.
    for (int i = 0; i < 3; i++) begin
      man_pulse = 1;
      tick();
      chk("t6_idle_dv", i_data_valid | d_data_valid | i_done | d_done, 0);
    end
    serve_set(0, 1, 0);
    serve_set(1, 0, 0);

    // Random request mixes against the arbitration model.
    for (int it = 0; it < 20; it++) begin
      int s = int'($urandom_range(1, 7));
      serve_set(s[0], s[1], s[2]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
